// File: rtl/slon5_core.sv
// Purpose: fully pipelined single-block MD5 of a 32-bit little-endian number, one hash per clock.
// Latency: 66 clocks from sw sampled to dout/dnum (input register, 64 round stages, output register).
// Backpressure: none; accepts a new number every clock, outputs are held at 0 until the pipe has filled.
module slon5_core #(
  parameter int WORD_WIDTH = 32,  // MD5 word width, fixed at 32
  parameter int STAGE_NUM  = 64,  // one MD5 round per stage, fixed at 64
  parameter int DNUM_WIDTH = 32   // number width, equal to one MD5 word
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DNUM_WIDTH-1:0] sw,
  output logic [127:0]          dout,
  output logic [DNUM_WIDTH-1:0] dnum
);

  localparam int LATENCY = STAGE_NUM + 2;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t IV_A = 32'h67452301;
  localparam word_t IV_B = 32'hefcdab89;
  localparam word_t IV_C = 32'h98badcfe;
  localparam word_t IV_D = 32'h10325476;

  localparam word_t K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate left; n is never 0 so the right shift never reaches the full width.
  function automatic word_t rotl(input word_t x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  // Per-round shift amount: four values per 16-round group, cycling every 4 rounds.
  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    logic [4:0] s;
    case ({i[5:4], i[1:0]})
      4'b0000: s = 5'd7;
      4'b0001: s = 5'd12;
      4'b0010: s = 5'd17;
      4'b0011: s = 5'd22;
      4'b0100: s = 5'd5;
      4'b0101: s = 5'd9;
      4'b0110: s = 5'd14;
      4'b0111: s = 5'd20;
      4'b1000: s = 5'd4;
      4'b1001: s = 5'd11;
      4'b1010: s = 5'd16;
      4'b1011: s = 5'd23;
      4'b1100: s = 5'd6;
      4'b1101: s = 5'd10;
      4'b1110: s = 5'd15;
      default: s = 5'd21;
    endcase
    return s;
  endfunction

  // Padded message block: only word 0 varies, the rest are padding/length constants.
  function automatic word_t msg_word(input logic [3:0] g, input word_t m0);
    word_t w;
    case (g)
      4'd0:    w = m0;
      4'd1:    w = word_t'(32'h00000080);
      4'd14:   w = word_t'(32'd32);
      default: w = '0;
    endcase
    return w;
  endfunction

  // One MD5 round; returns the new B (the other words just rotate positions).
  function automatic word_t md5_round(input logic [5:0] i, input word_t a, input word_t b,
                                      input word_t c, input word_t d, input word_t m0);
    word_t      f;
    logic [3:0] g;
    word_t      tmp;
    case (i[5:4])
      2'd0: begin
        f = (b & c) | (~b & d);
        g = i[3:0];
      end
      2'd1: begin
        f = (d & b) | (~d & c);
        g = 4'(5 * i + 1);
      end
      2'd2: begin
        f = b ^ c ^ d;
        g = 4'(3 * i + 5);
      end
      default: begin
        f = c ^ (b | ~d);
        g = 4'(7 * i);
      end
    endcase
    tmp = a + f + K_TAB[i] + msg_word(g, m0);
    return b + rotl(tmp, shift_amt(i));
  endfunction

  function automatic word_t bswap(input word_t x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Index 0 is the input register, index s holds the state after round s-1.
  word_t                 a_q  [STAGE_NUM+1];
  word_t                 a_d  [STAGE_NUM+1];
  word_t                 b_q  [STAGE_NUM+1];
  word_t                 b_d  [STAGE_NUM+1];
  word_t                 c_q  [STAGE_NUM+1];
  word_t                 c_d  [STAGE_NUM+1];
  word_t                 d_q  [STAGE_NUM+1];
  word_t                 d_d  [STAGE_NUM+1];
  word_t                 m0_q [STAGE_NUM+1];
  word_t                 m0_d [STAGE_NUM+1];
  logic [DNUM_WIDTH-1:0] num_q[STAGE_NUM+1];
  logic [DNUM_WIDTH-1:0] num_d[STAGE_NUM+1];

  logic [6:0]            cnt_q;
  logic [6:0]            cnt_d;
  logic [127:0]          dout_q;
  logic [127:0]          dout_d;
  logic [DNUM_WIDTH-1:0] dnum_q;
  logic [DNUM_WIDTH-1:0] dnum_d;
  word_t                 fin_a;
  word_t                 fin_b;
  word_t                 fin_c;
  word_t                 fin_d;

  // Round pipeline: stage 0 loads the IV and the number, each later stage applies one round.
  always_comb begin
    a_d[0]   = IV_A;
    b_d[0]   = IV_B;
    c_d[0]   = IV_C;
    d_d[0]   = IV_D;
    m0_d[0]  = word_t'(sw);
    num_d[0] = sw;
    for (int s = 1; s <= STAGE_NUM; s++) begin
      a_d[s]   = d_q[s-1];
      d_d[s]   = c_q[s-1];
      c_d[s]   = b_q[s-1];
      b_d[s]   = md5_round(6'(s - 1), a_q[s-1], b_q[s-1], c_q[s-1], d_q[s-1], m0_q[s-1]);
      m0_d[s]  = m0_q[s-1];
      num_d[s] = num_q[s-1];
    end
  end

  // Fill counter and output stage: results pass only once the counter reaches LATENCY.
  always_comb begin
    cnt_d  = (cnt_q == 7'(LATENCY)) ? cnt_q : cnt_q + 7'd1;
    fin_a  = a_q[STAGE_NUM] + IV_A;
    fin_b  = b_q[STAGE_NUM] + IV_B;
    fin_c  = c_q[STAGE_NUM] + IV_C;
    fin_d  = d_q[STAGE_NUM] + IV_D;
    dout_d = '0;
    dnum_d = '0;
    if (cnt_d == 7'(LATENCY)) begin
      dout_d = {bswap(fin_a), bswap(fin_b), bswap(fin_c), bswap(fin_d)};
      dnum_d = num_q[STAGE_NUM];
    end
  end

  // All state clears asynchronously so outputs drop to 0 the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGE_NUM; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        c_q[s]   <= '0;
        d_q[s]   <= '0;
        m0_q[s]  <= '0;
        num_q[s] <= '0;
      end
      cnt_q  <= '0;
      dout_q <= '0;
      dnum_q <= '0;
    end else begin
      for (int s = 0; s <= STAGE_NUM; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        c_q[s]   <= c_d[s];
        d_q[s]   <= d_d[s];
        m0_q[s]  <= m0_d[s];
        num_q[s] <= num_d[s];
      end
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      dnum_q <= dnum_d;
    end
  end

  assign dout = dout_q;
  assign dnum = dnum_q;

endmodule

// File: tb/tb_slon5_core.sv
// Bench for slon5_core: known-answer table, wrap sequence, streaming counter and mid-stream reset.
// Expected digests come from hardcoded known answers or a bench-side MD5 model with K derived from sin().
// Outputs sampled 1 time unit after each rising edge; scoreboard queue holds one entry per sampled number.
module tb_slon5_core;

  localparam int LAT = 66;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [31:0]  sw    = '0;
  logic [127:0] dout;
  logic [31:0]  dnum;

  slon5_core dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .dout (dout),
    .dnum (dnum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  num;
    logic [127:0] dig;
  } exp_t;

  typedef struct {
    logic [31:0]  sw;
    logic [127:0] dig;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[5];
  logic [31:0] kt[64];
  int          errors = 0;
  int          checks = 0;
  int          edges  = 0;

  function automatic logic [31:0] bs(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Straightforward software MD5 of a 4-byte message.
  function automatic logic [127:0] md5_ref(input logic [31:0] x);
    int          sh[4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    logic [31:0] m[16];
    logic [31:0] a, b, c, d, f, t, r;
    int          g, s;
    for (int j = 0; j < 16; j++) m[j] = '0;
    m[0]  = x;
    m[1]  = 32'h80;
    m[14] = 32'd32;
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      s = sh[i / 16][i % 4];
      t = a + f + kt[i] + m[g];
      r = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = b + r;
    end
    return {bs(a + 32'h67452301), bs(b + 32'hefcdab89), bs(c + 32'h98badcfe), bs(d + 32'h10325476)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edges, act, req);
    end
  endtask

  // Drive one number, advance one clock, compare whatever the pipe delivers.
  task automatic tick(input logic [31:0] v, input logic [127:0] dig);
    exp_t e;
    sw = v;
    sbq.push_back('{num: v, dig: dig});
    @(posedge clk);
    #1;
    edges++;
    if (edges >= LAT) begin
      e = sbq.pop_front();
      check("dnum", {96'd0, dnum}, {96'd0, e.num});
      check("dout", dout, e.dig);
    end else begin
      check("fill_dnum", {96'd0, dnum}, 128'd0);
      check("fill_dout", dout, 128'd0);
    end
  endtask

  // Assert reset between edges, check the asynchronous drop, hold with toggling input.
  task automatic do_reset(input int nclk);
    rst_n = 1'b0;
    #1;
    check("rst_async_dout", dout, 128'd0);
    check("rst_async_dnum", {96'd0, dnum}, 128'd0);
    sbq.delete();
    edges = 0;
    repeat (nclk) begin
      sw = $urandom;
      @(posedge clk);
      #1;
      check("rst_hold_dout", dout, 128'd0);
      check("rst_hold_dnum", {96'd0, dnum}, 128'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    real r;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end

    tbl[0] = '{sw: 32'h00000000, dig: 128'hf1d3ff8443297732862df21dc4e57262};
    tbl[1] = '{sw: 32'h64636261, dig: 128'he2fc714c4727ee9395f324cd2e7f331f};
    tbl[2] = '{sw: 32'hfffffffe, dig: md5_ref(32'hfffffffe)};
    tbl[3] = '{sw: 32'hffffffff, dig: md5_ref(32'hffffffff)};
    tbl[4] = '{sw: 32'h00000000, dig: md5_ref(32'h00000000)};

    #2;
    do_reset(5);

    // Known answers and wrap sequence, followed by a streaming counter.
    for (int i = 0; i < 5; i++) tick(tbl[i].sw, tbl[i].dig);
    for (int n = 0; n < 95; n++) tick(32'(n), md5_ref(32'(n)));

    // Mid-stream reset for 3 clocks, then a counter from 0 streamed gaplessly.
    do_reset(3);
    for (int n = 0; n < 200; n++) tick(32'(n), md5_ref(32'(n)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
